// File: rtl/spi_slave_word_if.sv
// Pin and handshake bundle for spi_slave_word: SPI pins, TX/RX streams, status and FSM debug.
// valid/ready: a word moves on a clk edge where valid && ready; the source holds data and valid until then.
interface spi_slave_word_if #(
  parameter int WORD_W = 8
);
  logic              spi_clk;
  logic              spi_cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [WORD_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              busy;
  logic              overrun;
  logic              dbg_state;

  modport slave (
    input  spi_clk, spi_cs_n, mosi, tx_data, tx_valid, rx_ready,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun, dbg_state
  );

  modport master (
    output spi_clk, spi_cs_n, mosi, tx_data, tx_valid, rx_ready,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun, dbg_state
  );
endinterface

// File: rtl/spi_slave_word.sv
// Word-wide SPI slave with CPOL/CPHA, bit order, chip select, TX holding register and RX handshake.
// Optional sticky RX overrun flag is enabled by defining SPI_SLAVE_WORD_OVERRUN_EN.
module spi_slave_word #(
  parameter int              WORD_W      = 8,
  parameter bit              CPOL        = 1'b0,
  parameter bit              CPHA        = 1'b0,
  parameter bit              MSB_FIRST   = 1'b1,
  parameter int              SYNC_STAGES = 2,
  parameter logic [WORD_W-1:0] FILL      = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_slave_word_if.slave   bus
);

  localparam int                 CNT_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WORD_W - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_hist, cs_hist;
  logic                   sck_s, cs_s, mosi_s;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;
  logic                   cs_fall, cs_rise;

  logic                   do_load, do_sample, do_shift, word_done, cs_abort;
  logic [CNT_W-1:0]       bit_cnt;
  logic [WORD_W-1:0]      rx_sh, rx_next, tx_sh, hold_q, load_word;
  logic                   skip_q;
  logic                   tx_ready_q;
  logic [WORD_W-1:0]      rx_data_q;
  logic                   rx_valid_q;
  logic                   miso_q, miso_oe_q, busy_q, overrun_q;

  // Synchronisers reset to the idle bus: SCK at CPOL, deselected, MOSI low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_hist  <= CPOL;
      cs_hist   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sck_hist  <= sck_sync[SYNC_STAGES-1];
      cs_hist   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s       = sck_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign lead_edge   = (sck_hist == CPOL) && (sck_s != CPOL);
  assign trail_edge  = (sck_hist != CPOL) && (sck_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;
  assign cs_fall     = cs_hist && !cs_s;
  assign cs_rise     = !cs_hist && cs_s;

  function automatic logic first_bit(input logic [WORD_W-1:0] w);
    return MSB_FIRST ? w[WORD_W-1] : w[0];
  endfunction

  function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign rx_next   = MSB_FIRST ? {rx_sh[WORD_W-2:0], mosi_s} : {mosi_s, rx_sh[WORD_W-1:1]};
  assign load_word = tx_ready_q ? FILL : hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    do_load   = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    word_done = 1'b0;
    cs_abort  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_ACTIVE;
          do_load = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d  = ST_IDLE;
          cs_abort = 1'b1;
        end else begin
          if (sample_edge) begin
            do_sample = 1'b1;
            if (bit_cnt == LAST_BIT) begin
              word_done = 1'b1;
              do_load   = 1'b1;
            end
          end
          if (shift_edge && !skip_q) do_shift = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      rx_sh   <= '0;
    end else if (cs_abort) begin
      bit_cnt <= '0;
      rx_sh   <= '0;
    end else if (do_sample) begin
      rx_sh   <= rx_next;
      bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
    end
  end

  // With CPHA=0 a word-boundary load already drives the first bit, so the
  // trailing edge that follows must not advance the shifter again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 skip_q <= 1'b0;
    else if (cs_abort)                          skip_q <= 1'b0;
    else if (word_done)                         skip_q <= !CPHA;
    else if (shift_edge && state_q == ST_ACTIVE) skip_q <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_q <= 1'b0;
      tx_sh  <= '0;
    end else if (do_load) begin
      if (!CPHA) begin
        miso_q <= first_bit(load_word);
        tx_sh  <= advance(load_word);
      end else begin
        tx_sh  <= load_word;
      end
    end else if (do_shift) begin
      miso_q <= first_bit(tx_sh);
      tx_sh  <= advance(tx_sh);
    end
  end

  // A load and an accept never collide on a full holder: accept needs it empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      tx_ready_q <= 1'b1;
    end else if (bus.tx_valid && tx_ready_q) begin
      hold_q     <= bus.tx_data;
      tx_ready_q <= 1'b0;
    end else if (do_load && !tx_ready_q) begin
      tx_ready_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else if (word_done) begin
      rx_data_q  <= rx_next;
      rx_valid_q <= 1'b1;
    end else if (bus.rx_ready && rx_valid_q) begin
      rx_valid_q <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_WORD_OVERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         overrun_q <= 1'b0;
    else if (word_done && rx_valid_q && !bus.rx_ready)  overrun_q <= 1'b1;
    else if (bus.rx_ready && overrun_q)                 overrun_q <= 1'b0;
  end
`else
  assign overrun_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      miso_oe_q <= 1'b0;
    end else begin
      busy_q    <= (state_d == ST_ACTIVE);
      miso_oe_q <= (state_d == ST_ACTIVE);
    end
  end

  assign bus.miso      = miso_q;
  assign bus.miso_oe   = miso_oe_q;
  assign bus.tx_ready  = tx_ready_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: a mode-0 8-bit MSB-first slave and a mode-3 16-bit LSB-first slave
// on shared SCK/MOSI, driven by a bit-level SPI master and checked against a word-level model.
module tb_spi_slave_word;

  localparam int HALF = 8;
  localparam int W0   = 8;
  localparam int W1   = 16;
`ifdef SPI_SLAVE_WORD_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sck_ph   = 1'b0;
  logic        mosi_pin = 1'b0;
  logic [1:0]  cs_n     = 2'b11;
  logic [31:0] tx_data_d [2] = '{32'h0, 32'h0};
  logic [1:0]  tx_valid_d = 2'b00;
  logic [1:0]  rx_ready_d = 2'b00;

  spi_slave_word_if #(.WORD_W(W0)) if0 ();
  spi_slave_word_if #(.WORD_W(W1)) if1 ();

  assign if0.spi_clk  = sck_ph;
  assign if1.spi_clk  = ~sck_ph;
  assign if0.spi_cs_n = cs_n[0];
  assign if1.spi_cs_n = cs_n[1];
  assign if0.mosi     = mosi_pin;
  assign if1.mosi     = mosi_pin;
  assign if0.tx_data  = tx_data_d[0][W0-1:0];
  assign if1.tx_data  = tx_data_d[1][W1-1:0];
  assign if0.tx_valid = tx_valid_d[0];
  assign if1.tx_valid = tx_valid_d[1];
  assign if0.rx_ready = rx_ready_d[0];
  assign if1.rx_ready = rx_ready_d[1];

  spi_slave_word #(.WORD_W(W0), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1),
                   .SYNC_STAGES(2), .FILL(8'hFF)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  spi_slave_word #(.WORD_W(W1), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0),
                   .SYNC_STAGES(3), .FILL(16'h0000)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic [31:0] rx_data_m [2];
  logic [1:0]  rx_valid_m, tx_ready_m, miso_m, oe_m, busy_m, ovr_m;
  assign rx_data_m[0] = 32'(if0.rx_data);
  assign rx_data_m[1] = 32'(if1.rx_data);
  assign rx_valid_m   = {if1.rx_valid, if0.rx_valid};
  assign tx_ready_m   = {if1.tx_ready, if0.tx_ready};
  assign miso_m       = {if1.miso,     if0.miso};
  assign oe_m         = {if1.miso_oe,  if0.miso_oe};
  assign busy_m       = {if1.busy,     if0.busy};
  assign ovr_m        = {if1.overrun,  if0.overrun};

  int          wd     [2] = '{W0, W1};
  bit          cpha_c [2] = '{1'b0, 1'b1};
  bit          msb_c  [2] = '{1'b1, 1'b0};
  logic [31:0] fill_c [2] = '{32'h0000_00FF, 32'h0000_0000};

  // reference model: pending TX words, expected RX words, overrun, word the slave is shifting out
  logic [31:0] pend[$];
  logic [31:0] exp_q[$];
  bit          ovr_model = 1'b0;
  logic [31:0] cur_tx    = '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  bit mon_en  = 1'b0;
  bit tx_drop = 1'b0;
  always @(negedge clk) begin
    if (!mon_en)             tx_drop <= 1'b0;
    else if (!tx_ready_m[0]) tx_drop <= 1'b1;
  end

  function automatic logic [31:0] wmask(input int sel);
    return (wd[sel] >= 32) ? 32'hFFFF_FFFF : ((32'h1 << wd[sel]) - 32'h1);
  endfunction

  function automatic logic [31:0] next_tx(input int sel);
    if (pend.size() != 0) return pend.pop_front();
    return fill_c[sel];
  endfunction

  // driver tasks
  task automatic push_tx(input int sel, input logic [31:0] data);
    int t;
    t = 0;
    @(negedge clk);
    while (!tx_ready_m[sel] && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("tx_ready_wait", 32'(tx_ready_m[sel]), 32'h1);
    tx_data_d[sel]  = data;
    tx_valid_d[sel] = 1'b1;
    @(negedge clk);
    tx_valid_d[sel] = 1'b0;
    pend.push_back(data & wmask(sel));
    check("tx_ready_full", 32'(tx_ready_m[sel]), 32'h0);
  endtask

  task automatic cs_low(input int sel);
    @(negedge clk);
    cs_n[sel] = 1'b0;
    repeat (HALF) @(negedge clk);
    cur_tx = next_tx(sel);
  endtask

  task automatic cs_high(input int sel);
    @(negedge clk);
    cs_n[sel] = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_bits(input int sel, input int nbits, input logic [31:0] mo,
                          output logic [31:0] mi);
    int b;
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      b = msb_c[sel] ? wd[sel] - 1 - i : i;
      if (!cpha_c[sel]) mosi_pin = mo[b];
      repeat (HALF) @(negedge clk);
      if (!cpha_c[sel]) mi[b] = miso_m[sel];
      sck_ph = 1'b1;
      if (cpha_c[sel]) mosi_pin = mo[b];
      repeat (HALF) @(negedge clk);
      if (cpha_c[sel]) mi[b] = miso_m[sel];
      sck_ph = 1'b0;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic check_rx(input int sel, input string tag);
    check({tag, "_rx_valid"}, 32'(rx_valid_m[sel]), 32'h1);
    check({tag, "_rx_data"},  rx_data_m[sel], exp_q[$]);
    check({tag, "_overrun"},  32'(ovr_m[sel]), 32'(ovr_model));
    @(negedge clk);
    rx_ready_d[sel] = 1'b1;
    @(negedge clk);
    rx_ready_d[sel] = 1'b0;
    exp_q.delete();
    ovr_model = 1'b0;
    check({tag, "_rx_clear"}, 32'(rx_valid_m[sel]), 32'h0);
    check({tag, "_ovr_clear"}, 32'(ovr_m[sel]), 32'h0);
  endtask

  task automatic xfer_word(input int sel, input logic [31:0] mo, input bit read, input string tag);
    logic [31:0] mi;
    spi_bits(sel, wd[sel], mo, mi);
    check({tag, "_miso_word"}, mi, cur_tx);
    if (exp_q.size() != 0) ovr_model = OVR_EN;
    exp_q.push_back(mo & wmask(sel));
    cur_tx = next_tx(sel);
    if (read) check_rx(sel, tag);
  endtask

  task automatic check_reset(input string tag);
    for (int s = 0; s < 2; s++) begin
      check({tag, "_miso"},     32'(miso_m[s]),     32'h0);
      check({tag, "_miso_oe"},  32'(oe_m[s]),       32'h0);
      check({tag, "_rx_valid"}, 32'(rx_valid_m[s]), 32'h0);
      check({tag, "_rx_data"},  rx_data_m[s],       32'h0);
      check({tag, "_busy"},     32'(busy_m[s]),     32'h0);
      check({tag, "_overrun"},  32'(ovr_m[s]),      32'h0);
      check({tag, "_tx_ready"}, 32'(tx_ready_m[s]), 32'h1);
    end
  endtask

  initial begin : main
    logic [31:0] mi;
    int sel, nw;

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // mode 0, 8-bit MSB first: A5 out, 3C in
    push_tx(0, 32'hA5);
    cs_low(0);
    check("t1_busy",     32'(busy_m[0]),     32'h1);
    check("t1_miso_oe",  32'(oe_m[0]),       32'h1);
    check("t1_tx_ready", 32'(tx_ready_m[0]), 32'h1);
    check("t1_model_tx", cur_tx,             32'hA5);
    xfer_word(0, 32'h3C, 1'b1, "t1");
    cs_high(0);
    check("t1_oe_off",   32'(oe_m[0]),   32'h0);
    check("t1_busy_off", 32'(busy_m[0]), 32'h0);

    // mode 3, 16-bit LSB first: BEEF out, 1234 in
    push_tx(1, 32'hBEEF);
    cs_low(1);
    xfer_word(1, 32'h1234, 1'b1, "t2");
    cs_high(1);

    // no pending word: FILL goes out and the holder stays empty
    mon_en = 1'b1;
    cs_low(0);
    xfer_word(0, $urandom, 1'b1, "t3");
    cs_high(0);
    check("t3_tx_ready_held", 32'(tx_drop), 32'h0);
    mon_en = 1'b0;

    // two words back to back, no read in between
    cs_low(0);
    xfer_word(0, $urandom, 1'b0, "t4a");
    xfer_word(0, $urandom, 1'b0, "t4b");
    check("t4_overrun", 32'(ovr_m[0]), 32'(OVR_EN));
    check_rx(0, "t4");
    cs_high(0);

    // abort after 5 bits, then a clean 0x81
    cs_low(0);
    spi_bits(0, 5, $urandom, mi);
    cs_high(0);
    check("t5_no_valid", 32'(rx_valid_m[0]), 32'h0);
    check("t5_oe_off",   32'(oe_m[0]),       32'h0);
    cs_low(0);
    xfer_word(0, 32'h81, 1'b1, "t5");
    cs_high(0);

    // asynchronous reset in the middle of a word
    push_tx(1, $urandom);
    cs_low(1);
    xfer_word(1, $urandom | 32'h1, 1'b0, "t6pre");
    spi_bits(1, 5, $urandom, mi);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("t6_async");
    cs_n = 2'b11;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pend.delete();
    exp_q.delete();
    ovr_model = 1'b0;
    repeat (2) @(negedge clk);
    push_tx(1, $urandom);
    cs_low(1);
    xfer_word(1, $urandom, 1'b1, "t6post");
    cs_high(1);

    // randomized sessions
    for (int it = 0; it < 10; it++) begin
      sel = $urandom_range(0, 1);
      nw  = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) push_tx(sel, $urandom);
      cs_low(sel);
      for (int k = 0; k < nw; k++) begin
        xfer_word(sel, $urandom, 1'b1, "rand");
        if (k < nw - 1 && $urandom_range(0, 1) == 1) push_tx(sel, $urandom);
      end
      cs_high(sel);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
